// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states and ALU control encodings for the
// multicycle controller.
package ctrl_pkg;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_RFN = 2'b10,
        ALU_IFN = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_FOUR = 2'd1,
        SRCB_IMM  = 2'd2
    } alu_src_b_t;

    typedef struct packed {
        alu_src_b_t src_b;
        alu_op_t    op;
        logic       pc_write;
        logic       pc_src;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       legal;
    } exec_ctl_t;

endpackage

// File: rtl/exec_decode.sv
// Per-opcode EXEC control decode; also classifies the opcode so the
// FSM can pick the next state.
module exec_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    output exec_ctl_t  ctl_o
);

    always_comb begin
        ctl_o       = '0;
        ctl_o.src_b = SRCB_RS2;
        ctl_o.op    = ALU_ADD;
        unique case (opcode_i)
            OPC_R: begin
                ctl_o.op    = ALU_RFN;
                ctl_o.legal = 1'b1;
            end
            OPC_I: begin
                ctl_o.src_b = SRCB_IMM;
                ctl_o.op    = ALU_IFN;
                ctl_o.legal = 1'b1;
            end
            OPC_LD: begin
                ctl_o.src_b   = SRCB_IMM;
                ctl_o.is_load = 1'b1;
                ctl_o.legal   = 1'b1;
            end
            OPC_ST: begin
                ctl_o.src_b    = SRCB_IMM;
                ctl_o.is_store = 1'b1;
                ctl_o.legal    = 1'b1;
            end
            OPC_BR: begin
                ctl_o.op        = ALU_SUB;
                ctl_o.pc_write  = zero_i;
                ctl_o.pc_src    = 1'b1;
                ctl_o.is_branch = 1'b1;
                ctl_o.legal     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with memory timeout and sticky traps.
// Optional perf counters: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic [2:0]       state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TO - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;
    exec_ctl_t  dec;
    logic       unused_instr;

    assign unused_instr = ^instr[31:7];

    exec_decode u_dec (
        .opcode_i (instr[6:0]),
        .zero_i   (zero),
        .ctl_o    (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        trap_d     = trap_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        pc_src     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    state_d   = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_MEM_TO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM;
                if (dec.legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = dec.src_b;
                alu_op    = dec.op;
                pc_write  = dec.pc_write;
                pc_src    = dec.pc_src;
                if (dec.is_load || dec.is_store) state_d = S_MEMACC;
                else if (dec.is_branch)          state_d = S_FETCH;
                else                             state_d = S_WB;
            end
            S_MEMACC: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = dec.is_store;
                if (mem_ready) begin
                    state_d = dec.is_store ? S_FETCH : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_MEM_TO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = dec.is_load;
                state_d    = S_FETCH;
            end
            S_TRAP: ;
            default: state_d = S_FETCH;
        endcase
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_q, ret_q;
    logic             retire;

    // An instruction retires on its final cycle, whichever state that is.
    assign retire = (state_q == S_WB)
                  | ((state_q == S_EXEC) & dec.is_branch)
                  | ((state_q == S_MEMACC) & mem_ready & dec.is_store);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_TRAP) cyc_q <= cyc_q + 1'b1;
            if (retire)            ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; perf counter checks are built
// when MULTICYCLE_CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready, zero;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic        reg_write, mem_to_reg, alu_src_a, pc_src, trap;
    logic [1:0]  alu_src_b, alu_op, trap_cause;
    logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [3:0]  cycle_cnt, instret_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD = 32'h00208033;
    localparam logic [31:0] I_LD  = 32'h00002003;
    localparam logic [31:0] I_ST  = 32'h00002023;
    localparam logic [31:0] I_BR  = 32'h00000063;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    multicycle_ctrl #(.CNT_W(4), .MEM_TO(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .trap       (trap),
        .trap_cause (trap_cause),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        check("rst_state", state, 0);
        check("rst_trap", trap, 0);
        check("rst_cause", trap_cause, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        instr     = I_ADD;
        mem_ready = 1'b1;
        zero      = 1'b0;
        do_reset();

        // add: FETCH-DECODE-EXEC-WB, then 19 more
        check("add_fetch_req", mem_req, 1);
        check("add_fetch_iord", iord, 0);
        check("add_fetch_irw", ir_write, 1);
        check("add_fetch_pcw", pc_write, 1);
        check("add_fetch_srcb", alu_src_b, 1);
        tick(1);
        check("add_dec_state", state, 1);
        check("add_dec_srcb", alu_src_b, 2);
        tick(1);
        check("add_ex_state", state, 2);
        check("add_ex_op", alu_op, 2);
        check("add_ex_srca", alu_src_a, 1);
        check("add_ex_srcb", alu_src_b, 0);
        tick(1);
        check("add_wb_state", state, 4);
        check("add_wb_rw", reg_write, 1);
        check("add_wb_m2r", mem_to_reg, 0);
        tick(1);
        check("add_done", state, 0);
        tick(76);
        check("add20_state", state, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf_cycle", cycle_cnt, 0);
        check("perf_instret", instret_cnt, 4);
`endif

        // load, 3 memory wait cycles
        instr = I_LD;
        tick(2);
        check("ld_ex_srcb", alu_src_b, 2);
        check("ld_ex_op", alu_op, 0);
        tick(1);
        mem_ready = 1'b0;
        check("ld_mem_state", state, 3);
        check("ld_mem_iord", iord, 1);
        check("ld_mem_req", mem_req, 1);
        check("ld_mem_we", mem_we, 0);
        tick(3);
        check("ld_mem_hold", state, 3);
        mem_ready = 1'b1;
        tick(1);
        check("ld_wb_state", state, 4);
        check("ld_wb_m2r", mem_to_reg, 1);
        tick(1);
        check("ld_8cyc", state, 0);

        // store, zero wait
        instr = I_ST;
        tick(3);
        check("st_mem_we", mem_we, 1);
        tick(1);
        check("st_4cyc", state, 0);

        // branch taken / not taken
        instr = I_BR;
        zero  = 1'b1;
        tick(2);
        check("br1_pcw", pc_write, 1);
        check("br1_pcsrc", pc_src, 1);
        check("br1_op", alu_op, 1);
        tick(1);
        check("br1_3cyc", state, 0);
        zero = 1'b0;
        tick(2);
        check("br0_pcw", pc_write, 0);
        tick(1);
        check("br0_3cyc", state, 0);

        // fetch timeout
        mem_ready = 1'b0;
        tick(14);
        check("to_14_state", state, 0);
        check("to_14_trap", trap, 0);
        tick(1);
        check("to_state", state, 5);
        check("to_trap", trap, 1);
        check("to_cause", trap_cause, 2);
        check("to_no_req", mem_req, 0);

        // async reset in the middle of MEMACC
        mem_ready = 1'b1;
        instr = I_LD;
        do_reset();
        tick(3);
        mem_ready = 1'b0;
        check("mrst_in_mem", state, 3);
        tick(1);
        #2 rst = 1'b1;
        #1;
        check("mrst_state", state, 0);
        check("mrst_trap", trap, 0);
        check("mrst_iord", iord, 0);
        tick(1);
        rst = 1'b0;
        mem_ready = 1'b1;
        check("mrst_fetch_req", mem_req, 1);

        // illegal opcode, sticky
        instr = I_BAD;
        tick(1);
        check("ill_dec_trap", trap, 0);
        tick(1);
        check("ill_state", state, 5);
        check("ill_trap", trap, 1);
        check("ill_cause", trap_cause, 1);
        tick(10);
        check("ill_hold_state", state, 5);
        check("ill_hold_trap", trap, 1);
        check("ill_hold_irw", ir_write, 0);
        check("ill_hold_req", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-002 SHALL have parameter MEM_TO, default 15: the maximum number of cycles to wait for mem_ready before trapping (1..255).
REQ-003 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port instr, input, 32: the instruction register contents; only bits [6:0] (the opcode) are used.
REQ-006 SHALL have port mem_ready, input, 1: memory completion for the current mem_req.
REQ-007 SHALL have port zero, input, 1: the ALU zero flag.
REQ-008 SHALL have port mem_req, output, 1: memory access request.
REQ-009 SHALL have port mem_we, output, 1: store write enable.
REQ-010 SHALL have port iord, output, 1: address select, 0=PC, 1=ALUOut.
REQ-011 SHALL have ports ir_write, pc_write, reg_write and mem_to_reg, each output, 1: the datapath enables.
REQ-012 SHALL have ports alu_src_a (output, 1: 0=PC, 1=rs1) and alu_src_b (output, 2: 0=rs2, 1=const 4, 2=imm).
REQ-013 SHALL have port alu_op, output, 2: 00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct.
REQ-014 SHALL have port pc_src, output, 1: 0=ALU result, 1=ALUOut (branch target).
REQ-015 SHALL have ports trap (output, 1) and trap_cause (output, 2: 01 illegal opcode, 10 memory timeout).
REQ-016 SHALL have port state, output, 3: the current FSM state, for debug.

Function
REQ-017 SHALL implement states FETCH, DECODE, EXEC, MEMACC, WB and TRAP.
REQ-018 FETCH: mem_req=1, iord=0. The FSM SHALL hold in FETCH until mem_ready; in the mem_ready cycle it SHALL assert ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=1 and alu_op=00, then go to DECODE.
REQ-019 DECODE: alu_src_a=0, alu_src_b=2, alu_op=00 (branch target to ALUOut); always 1 cycle, then EXEC. If the opcode is not one of 0110011, 0010011, 0000011, 0100011 or 1100011, the next state SHALL be TRAP with cause 01.
REQ-020 EXEC, by opcode:
  - R: src_b=0, op=10.
  - I: src_b=2, op=11.
  - Load/store: src_b=2, op=00.
  - Branch: src_b=0, op=01; pc_write=zero and pc_src=1, then go to FETCH.
  - All EXEC uses alu_src_a=1.
REQ-021 Next state after EXEC: load/store go to MEMACC; R and I go to WB.
REQ-022 MEMACC: mem_req=1, iord=1, mem_we=1 for stores. The FSM SHALL hold until mem_ready; then a store goes to FETCH and a load goes to WB.
REQ-023 WB: reg_write=1; mem_to_reg=1 for loads, else 0; 1 cycle, then FETCH.
REQ-024 Cycle counts with zero-wait memory SHALL be R/I 4, load 5, store 4, branch 3; each memory wait cycle adds 1.
REQ-025 Memory timeout: a wait counter SHALL reset on entry to FETCH or MEMACC and increment each cycle mem_ready=0. When it reaches MEM_TO, the FSM SHALL go to TRAP with cause 10.
REQ-026 mem_ready outside FETCH/MEMACC SHALL be ignored.
REQ-027 TRAP is sticky: all enables=0 and trap=1 until rst.
REQ-028 All enable outputs SHALL be combinational from state, opcode and mem_ready. trap and trap_cause SHALL be registered.

Reset
REQ-029 rst SHALL force state=FETCH, wait counter=0, trap=0, trap_cause=00 and counters=0, asynchronously, including mid-access.
REQ-030 In the first cycle after rst deasserts the block SHALL issue a FETCH request.

Configuration
REQ-031 With MULTICYCLE_CTRL_PERF_EN defined, the block SHALL add outputs cycle_cnt and instret_cnt [CNT_W-1:0]:
  - cycle_cnt increments every non-TRAP cycle.
  - instret_cnt increments on each WB exit, store MEMACC completion and branch EXEC.
  - Both wrap modulo 2^CNT_W.
REQ-032 Without MULTICYCLE_CTRL_PERF_EN, these ports and their registers SHALL be absent.

Structure
REQ-033 Package ctrl_pkg SHALL hold the opcode constants, the state enum, and the alu_op and alu_src_b encodings.
REQ-034 The per-opcode EXEC decode SHALL be one combinational sub-module, exec_decode.

Verification
REQ-035 Bench SHALL drive instr=0x00208033 (add) with mem_ready=1 always and check FETCH-DECODE-EXEC-WB in 4 cycles, reg_write=1 in WB and alu_op=10 in EXEC.
REQ-036 Bench SHALL drive a load (opcode 0000011) with 3 wait cycles in MEMACC and check 8 cycles total, mem_to_reg=1 in WB and iord=1 in MEMACC.
REQ-037 Bench SHALL drive a branch with zero=1 and check pc_write=1 and pc_src=1 in EXEC and a return to FETCH after 3 cycles; with zero=0 it SHALL check pc_write=0.
REQ-038 Bench SHALL drive instr opcode 1111111 and check trap=1 with cause 01 after DECODE, and that trap holds through 10 further cycles.
REQ-039 Bench SHALL hold mem_ready=0 in FETCH with MEM_TO=15 and check TRAP with cause 10 after 15 cycles; then assert rst mid-MEMACC and check an immediate return to FETCH with trap=0.
REQ-040 Bench SHALL, with PERF_EN and CNT_W=4, run 20 R-type instructions and check instret_cnt=4 (wrapped) and cycle_cnt=(80 mod 16)=0.
